bin2gray_counter: RTL and testbench

- Up/down binary counter with a registered Gray-code output.
- Inverse companion of the team's Gray-to-binary decoder: it produces the Gray-coded pointers/counts that the decoder consumes.
- Intended as the pointer generator for FIFO read/write pointers and other values that must cross clock domains.
- The Gray output is driven directly from a flop, never from combinational logic, so it is glitch-free and changes exactly one bit per step.

---
 rtl/bin2gray_counter.sv | 81 ++++++++
 tb/tb_bin2gray_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2gray_counter.sv
// bin2gray_counter
// Up/down binary counter with a registered Gray-code output. It generates
// Gray-coded pointers (for example, FIFO read/write pointers) that cross
// clock domains and are decoded by the companion Gray-to-binary decoder.
// Both bin and gray come straight from flops. An en step therefore changes
// exactly one gray bit, and gray never glitches.
module bin2gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             step
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_step;

  logic [WIDTH-1:0] w_bin_nxt;
  logic [WIDTH-1:0] w_gray_nxt;
  logic             w_wrap_nxt;
  logic             w_step_nxt;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_bin == '1);
  assign w_at_zero = (r_bin == '0);

  // Next-state selection: load beats en; en steps up or down by one.
  always_comb begin
    w_bin_nxt  = r_bin;
    w_wrap_nxt = 1'b0;
    w_step_nxt = 1'b0;
    if (load) begin
      w_bin_nxt = load_val;
    end else if (en) begin
      w_step_nxt = 1'b1;
      if (up_dn) begin
        w_bin_nxt  = r_bin + 1'b1;
        w_wrap_nxt = w_at_max;
      end else begin
        w_bin_nxt  = r_bin - 1'b1;
        w_wrap_nxt = w_at_zero;
      end
    end
  end

  // Gray code of the next binary value, so that bin and gray register together.
  always_comb begin
    w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
  end

  // Count, Gray and pulse registers; rst clears them without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= w_gray_nxt;
      r_wrap <= w_wrap_nxt;
      r_step <= w_step_nxt;
    end
  end

  assign bin  = r_bin;
  assign gray = r_gray;
  assign wrap = r_wrap;
  assign step = r_step;

endmodule

// File: tb/tb_bin2gray_counter.sv
// Testbench for bin2gray_counter. It runs directed sequences on a WIDTH=4
// instance, then random regression on WIDTH=4 and WIDTH=8 instances. Both
// are checked against an arithmetic reference model.
module tb_bin2gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en4 = 1'b0, up4 = 1'b1, ld4 = 1'b0;
  logic [3:0] lv4 = '0;
  logic [3:0] bin4, gray4;
  logic       wrap4, step4;
  logic       en8 = 1'b0, up8 = 1'b1, ld8 = 1'b0;
  logic [7:0] lv8 = '0;
  logic [7:0] bin8, gray8;
  logic       wrap8, step8;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state, one set per instance.
  int unsigned m_bin4 = 0, m_bin8 = 0;
  bit          m_wrap4 = 0, m_step4 = 0, m_wrap8 = 0, m_step8 = 0;
  logic [7:0]  prev_gray4 = '0, prev_gray8 = '0;

  bin2gray_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .up_dn(up4), .load(ld4), .load_val(lv4),
    .bin(bin4), .gray(gray4), .wrap(wrap4), .step(step4)
  );

  bin2gray_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .up_dn(up8), .load(ld8), .load_val(lv8),
    .bin(bin8), .gray(gray8), .wrap(wrap8), .step(step8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-state rule: load beats en; en steps by one modulo 2^w.
  function automatic void ref_next(input int unsigned w, input int unsigned b,
                                   input bit l, input int unsigned lv, input bit e, input bit u,
                                   output int unsigned nb, output bit nw, output bit ns);
    int unsigned m;
    m = 1 << w;
    nb = b; nw = 0; ns = 0;
    if (l) begin
      nb = lv % m;
    end else if (e) begin
      ns = 1;
      if (u) begin
        nb = (b + 1) % m;
        nw = (nb == 0);
      end else begin
        nb = (b + m - 1) % m;
        nw = (b == 0);
      end
    end
  endfunction

  function automatic int unsigned to_gray(input int unsigned b);
    return b ^ (b >> 1);
  endfunction

  // Independent Gray-to-binary decoder (prefix XOR of all higher bits).
  function automatic int unsigned from_gray(input int unsigned g);
    int unsigned b, s;
    b = g;
    s = g >> 1;
    while (s != 0) begin
      b ^= s;
      s >>= 1;
    end
    return b;
  endfunction

  task automatic check_outs(input string tag, input int unsigned b, input int unsigned g,
                            input bit wr, input bit st, input int unsigned pg,
                            input int unsigned mb, input bit mw, input bit ms);
    chk({tag, ".bin"}, b, mb);
    chk({tag, ".gray"}, g, to_gray(mb));
    chk({tag, ".wrap"}, {31'd0, wr}, {31'd0, mw});
    chk({tag, ".step"}, {31'd0, st}, {31'd0, ms});
    chk({tag, ".decode"}, from_gray(g), b);
    if (ms) chk({tag, ".onebit"}, $countones(pg ^ g), 1);
  endtask

  // One clock: predict from the inputs present at the edge, then compare 1 ns later.
  task automatic cycle();
    int unsigned nb4, nb8;
    bit nw4, ns4, nw8, ns8;
    ref_next(4, m_bin4, ld4, lv4, en4, up4, nb4, nw4, ns4);
    ref_next(8, m_bin8, ld8, lv8, en8, up8, nb8, nw8, ns8);
    prev_gray4 = {4'd0, gray4};
    prev_gray8 = gray8;
    @(posedge clk);
    #1;
    m_bin4 = nb4; m_wrap4 = nw4; m_step4 = ns4;
    m_bin8 = nb8; m_wrap8 = nw8; m_step8 = ns8;
    check_outs("w4", bin4, gray4, wrap4, step4, prev_gray4, m_bin4, m_wrap4, m_step4);
    check_outs("w8", bin8, gray8, wrap8, step8, prev_gray8, m_bin8, m_wrap8, m_step8);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_bin4 = 0; m_wrap4 = 0; m_step4 = 0;
    m_bin8 = 0; m_wrap8 = 0; m_step8 = 0;
    chk("rst.bin4", bin4, 0);
    chk("rst.gray4", gray4, 0);
    chk("rst.wrap4", wrap4, 0);
    chk("rst.step4", step4, 0);
    chk("rst.bin8", bin8, 0);
    rst = 1'b0;
  endtask

  logic [3:0] gray_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    #2;
    do_reset();

    // Up-count through the full 4-bit Gray sequence, then the wrap.
    chk("seq0.gray", gray4, gray_seq[0]);
    en4 = 1; up4 = 1;
    for (int i = 1; i < 16; i++) begin
      cycle();
      chk("seq.gray", gray4, gray_seq[i]);
      chk("seq.step", step4, 1);
    end
    cycle();
    chk("upwrap.bin", bin4, 0);
    chk("upwrap.gray", gray4, 0);
    chk("upwrap.wrap", wrap4, 1);
    en4 = 0;
    cycle();
    chk("upwrap.pulse", wrap4, 0);

    // Down-count from zero.
    do_reset();
    en4 = 1; up4 = 0;
    cycle();
    chk("dn1.bin", bin4, 4'b1111);
    chk("dn1.gray", gray4, 4'b1000);
    chk("dn1.wrap", wrap4, 1);
    cycle();
    chk("dn2.bin", bin4, 4'b1110);
    chk("dn2.gray", gray4, 4'b1001);
    chk("dn2.wrap", wrap4, 0);

    // Load takes priority over en.
    ld4 = 1; lv4 = 4'b1010; en4 = 1; up4 = 1;
    cycle();
    chk("ld.bin", bin4, 4'b1010);
    chk("ld.gray", gray4, 4'b1111);
    chk("ld.step", step4, 0);
    chk("ld.wrap", wrap4, 0);
    ld4 = 0;
    cycle();
    chk("ldup.bin", bin4, 4'b1011);
    chk("ldup.gray", gray4, 4'b1110);

    // Up immediately followed by down returns to the same value.
    up4 = 0;
    cycle();
    chk("updn.bin", bin4, 4'b1010);

    // Hold.
    en4 = 0; ld4 = 1; lv4 = 4'b0101;
    cycle();
    ld4 = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold.bin", bin4, 4'b0101);
      chk("hold.gray", gray4, 4'b0111);
      chk("hold.wrap", wrap4, 0);
      chk("hold.step", step4, 0);
    end

    // Asynchronous reset between edges.
    ld4 = 1; lv4 = 4'b1001;
    cycle();
    ld4 = 0;
    chk("pre_arst.bin", bin4, 4'b1001);
    #2;
    rst = 1;
    #1;
    chk("arst.bin", bin4, 0);
    chk("arst.gray", gray4, 0);
    m_bin4 = 0; m_wrap4 = 0; m_step4 = 0;
    m_bin8 = 0; m_wrap8 = 0; m_step8 = 0;
    @(negedge clk);
    rst = 0;
    en4 = 1; up4 = 1;
    cycle();
    chk("arst.resume", gray4, 4'b0001);

    // Random regression on both widths.
    for (int i = 0; i < 10000; i++) begin
      en4 = $urandom_range(0, 3) != 0;
      up4 = $urandom_range(0, 1);
      ld4 = $urandom_range(0, 15) == 0;
      lv4 = 4'($urandom);
      en8 = $urandom_range(0, 3) != 0;
      up8 = $urandom_range(0, 4) != 0;
      ld8 = $urandom_range(0, 31) == 0;
      lv8 = 8'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
